// File: rtl/oam_dma_ctrl_if.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl_if
//   Groups the CPU-side and system-bus-side signals of the sprite-DMA
//   controller into one bundle.
//
//   CPU side : cpu_a, cpu_dout, cpu_we (from core), cpu_rdy (to core)
//   Bus side : bus_a, bus_dout, bus_we (to bus), bus_din (from bus)
//   Status   : dma_busy (high while the controller owns the bus)
//
//   slave  : view taken by the controller
//   master : view taken by the environment (core + memory)
// -----------------------------------------------------------------------------
interface oam_dma_ctrl_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic [7:0]  bus_din;
    logic        dma_busy;

    modport slave (
        input  cpu_a, cpu_dout, cpu_we, bus_din,
        output cpu_rdy, bus_a, bus_dout, bus_we, dma_busy
    );

    modport master (
        output cpu_a, cpu_dout, cpu_we, bus_din,
        input  cpu_rdy, bus_a, bus_dout, bus_we, dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//   Sprite-DMA controller and system-bus arbiter. A CPU write of a page number
//   to TRIGGER_ADDR halts the core (cpu_rdy=0), then XFER_LEN bytes are copied
//   from {page,8'h00} onward to DEST_ADDR, one read cycle and one write cycle
//   per byte. In IDLE the core's bus signals pass straight through.
//
// Ports
//   clk  : system clock, one CPU cycle per rising edge
//   rst  : asynchronous active-high reset
//   dma  : oam_dma_ctrl_if.slave
//          cpu_a/cpu_dout/cpu_we in, cpu_rdy out
//          bus_a/bus_dout/bus_we out, bus_din in
//          dma_busy out
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave dma
);

    // Count of the final byte; count_q is 9 bits so XFER_LEN=256 fits.
    localparam logic [8:0] LAST_CNT = 9'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  addr_lo_q, addr_lo_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  data_q, data_d;
    logic        par_q;

    logic [15:0] bus_a_c;
    logic [7:0]  bus_dout_c;
    logic        bus_we_c;

    // State register; par_q is a free-running cycle parity used to decide
    // whether the halt must be stretched by one alignment cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            addr_lo_q <= 8'h00;
            count_q   <= 9'd0;
            data_q    <= 8'h00;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            addr_lo_q <= addr_lo_d;
            count_q   <= count_d;
            data_q    <= data_d;
            par_q     <= ~par_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        addr_lo_d  = addr_lo_q;
        count_d    = count_q;
        data_d     = data_q;
        bus_a_c    = dma.cpu_a;
        bus_dout_c = dma.cpu_dout;
        bus_we_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The trigger write itself still reaches the bus.
                bus_we_c = dma.cpu_we;
                if (dma.cpu_we && (dma.cpu_a == TRIGGER_ADDR)) begin
                    page_d    = dma.cpu_dout;
                    addr_lo_d = 8'h00;
                    count_d   = 9'd0;
                    state_d   = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = par_q ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                bus_a_c = {page_q, addr_lo_q};
                data_d  = dma.bus_din;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                bus_a_c    = DEST_ADDR;
                bus_dout_c = data_q;
                bus_we_c   = 1'b1;
                // 8-bit increment: the source address wraps inside the page.
                addr_lo_d  = addr_lo_q + 8'd1;
                count_d    = count_q + 9'd1;
                state_d    = (count_q == LAST_CNT) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dma.bus_a    = bus_a_c;
    assign dma.bus_dout = bus_dout_c;
    assign dma.bus_we   = bus_we_c;
    assign dma.cpu_rdy  = (state_q == ST_IDLE);
    assign dma.dma_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    typedef struct {
        logic [15:0] src;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oam_dma_ctrl_if dif();

    oam_dma_ctrl #(
        .TRIGGER_ADDR(TRIG),
        .DEST_ADDR   (DEST),
        .XFER_LEN    (256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dma(dif)
    );

    // Memory model: combinational read data for the current bus address.
    logic [7:0] mem [0:65535];
    assign dif.bus_din = mem[dif.bus_a];

    int   total = 0;
    int   bad   = 0;
    int   writes_seen = 0;
    int   xfer_start  = 0;
    int   edge_cnt;
    exp_t exp_q[$];
    int   stall_q[$];

    // Edges since reset release; equals the DUT parity of the current cycle mod 2.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: checks every DMA write against the scoreboard and every stall
    // window length against the expected length.
    logic [15:0] prev_a = 16'h0000;
    int          low_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
        end else begin
            if (dif.bus_we && dif.dma_busy) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%h:%h required=none", dif.bus_a, dif.bus_dout);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(dif.bus_a), 32'(DEST));
                    chk("read_src",   32'(prev_a),    32'(e.src));
                    chk("write_data", 32'(dif.bus_dout), 32'(e.data));
                end
            end
            if (!dif.cpu_rdy) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (stall_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_stall actual=%0d required=none", low_cnt);
                end else begin
                    int req;
                    req = stall_q.pop_front();
                    chk("stall_len", 32'(low_cnt), 32'(req));
                    $display("xfer stall=%0d expected=%0d", low_cnt, req);
                end
                low_cnt = 0;
            end
        end
        prev_a = dif.bus_a;
    end

    // Called at a negedge; issues a trigger write for the next edge.
    // want_par: HALT parity to line up (0/1), or -1 for "as it comes".
    task automatic do_xfer(input logic [7:0] pg, input int want_par);
        int   p;
        exp_t e;
        if (want_par >= 0 && ((edge_cnt + 1) % 2) != want_par) @(negedge clk);
        p = (edge_cnt + 1) % 2;
        for (int i = 0; i < 256; i++) begin
            e.src  = {pg, 8'(i)};
            e.data = mem[{pg, 8'(i)}];
            exp_q.push_back(e);
        end
        stall_q.push_back(513 + p);
        xfer_start   = writes_seen;
        dif.cpu_a    = TRIG;
        dif.cpu_dout = pg;
        dif.cpu_we   = 1'b1;
        @(negedge clk);
        dif.cpu_we   = 1'b0;
        dif.cpu_a    = 16'h0123;
        dif.cpu_dout = 8'h00;
        chk("rdy_low_after_trigger", 32'(dif.cpu_rdy), 32'd0);
        chk("busy_after_trigger",    32'(dif.dma_busy), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (dif.dma_busy && n < 800) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (dif.dma_busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=busy required=idle", nm);
        end
        chk({nm, "_writes"},    32'(writes_seen - xfer_start), 32'd256);
        chk({nm, "_exp_left"},  32'(exp_q.size()), 32'd0);
        chk({nm, "_stall_left"}, 32'(stall_q.size()), 32'd0);
        chk({nm, "_rdy"},       32'(dif.cpu_rdy), 32'd1);
        $display("xfer %s done writes=%0d", nm, writes_seen - xfer_start);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] aa;
            aa = 16'(a);
            mem[a] = aa[7:0] ^ aa[15:8] ^ 8'h3C;
        end
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        dif.cpu_a    = 16'h1234;
        dif.cpu_dout = 8'h77;
        dif.cpu_we   = 1'b0;

        // Reset state
        #12;
        chk("rst_cpu_rdy",  32'(dif.cpu_rdy),  32'd1);
        chk("rst_busy",     32'(dif.dma_busy), 32'd0);
        chk("rst_bus_a",    32'(dif.bus_a),    32'h1234);
        chk("rst_bus_we",   32'(dif.bus_we),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Idle pass-through
        dif.cpu_a = 16'h0300; dif.cpu_dout = 8'h5A; dif.cpu_we = 1'b1;
        #1;
        chk("idle_bus_a",    32'(dif.bus_a),    32'h0300);
        chk("idle_bus_dout", 32'(dif.bus_dout), 32'h5A);
        chk("idle_bus_we",   32'(dif.bus_we),   32'd1);
        chk("idle_cpu_rdy",  32'(dif.cpu_rdy),  32'd1);
        chk("idle_busy",     32'(dif.dma_busy), 32'd0);
        $display("idle write a=%h d=%h we=%b", dif.bus_a, dif.bus_dout, dif.bus_we);
        @(negedge clk);
        dif.cpu_we = 1'b0;
        @(negedge clk);

        // Even-aligned transfer, with a retrigger attempt in the middle
        do_xfer(8'h02, 0);
        repeat (20) @(negedge clk);
        dif.cpu_a = TRIG; dif.cpu_dout = 8'h07; dif.cpu_we = 1'b1;
        repeat (8) @(negedge clk);
        dif.cpu_we = 1'b0; dif.cpu_a = 16'h0123;
        wait_done("even");
        @(negedge clk);

        // Odd-aligned transfer (one ALIGN cycle)
        do_xfer(8'h02, 1);
        wait_done("odd");

        // Back-to-back: trigger in the first IDLE cycle, page FF boundary
        do_xfer(8'hFF, -1);
        wait_done("pageff");
        @(negedge clk);

        // Reset mid-transfer after 100 writes
        do_xfer(8'h02, -1);
        begin
            int n;
            n = 0;
            while ((writes_seen - xfer_start) < 100 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        chk("pre_reset_writes", 32'(writes_seen - xfer_start), 32'd100);
        @(posedge clk);
        #2;
        dif.cpu_a = 16'h0300; dif.cpu_dout = 8'h5A; dif.cpu_we = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_cpu_rdy", 32'(dif.cpu_rdy),  32'd1);
        chk("mid_rst_busy",    32'(dif.dma_busy), 32'd0);
        chk("mid_rst_bus_we1", 32'(dif.bus_we),   32'd1);
        chk("mid_rst_bus_a",   32'(dif.bus_a),    32'h0300);
        dif.cpu_we = 1'b0;
        #1;
        chk("mid_rst_bus_we0", 32'(dif.bus_we),   32'd0);
        $display("reset mid-transfer after %0d writes", writes_seen - xfer_start);
        exp_q.delete();
        stall_q.delete();
        dif.cpu_a = 16'h0123;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_xfer(8'h02, -1);
        wait_done("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite-DMA controller and system-bus arbiter between the k6502 core and the PPU OAM port.
- A CPU write to the trigger register halts the CPU through `cpu_rdy` and takes ownership of the system bus.
- It copies XFER_LEN bytes from page `{page,8'h00}` to DEST_ADDR, one read and one write per byte, then returns the bus to the CPU.
- It sits between the core's address/data/write-enable outputs and the system bus.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
- DEST_ADDR, 16'h2004, fixed destination address for every write.
- XFER_LEN, 256, bytes per transfer. Range 1..256; the count register is 9 bits.

Ports:
- clk  input  1  system clock; one CPU cycle per rising edge.
- rst  input  1  asynchronous active-high reset.
- cpu_a  input  16  CPU address.
- cpu_dout  input  8  CPU write data.
- cpu_we  input  1  CPU write strobe.
- cpu_rdy  output  1  CPU ready; 0 stalls the core.
- bus_a  output  16  system-bus address.
- bus_dout  output  8  system-bus write data.
- bus_we  output  1  system-bus write strobe.
- bus_din  input  8  system-bus read data; valid combinationally in the same cycle as `bus_a`.
- dma_busy  output  1  high while the controller owns the bus.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst`) is asynchronous and active-high.
- Reset values:
  - state=IDLE, page=0, addr_lo=0, count=0, data_q=0, par=0.
  - cpu_rdy=1, dma_busy=0.
  - Bus outputs follow the CPU pass-through.
- Parity: `par` toggles on every clock edge, free-running, independent of state.
- States and transitions:
  - IDLE:
    - Bus outputs pass through: `bus_a=cpu_a`, `bus_dout=cpu_dout`, `bus_we=cpu_we`.
    - If `cpu_we && cpu_a==TRIGGER_ADDR` at an edge: latch `page<=cpu_dout`, `addr_lo<=0`, `count<=0`, go to HALT.
    - The trigger write itself completes on the bus normally.
  - HALT: one dummy cycle, then ALIGN if `par==1` in this cycle, otherwise READ.
  - ALIGN: one dummy cycle, then READ.
  - Dummy cycles (HALT, ALIGN): `bus_a=cpu_a`, `bus_we=0`.
  - READ:
    - `bus_a={page,addr_lo}`, `bus_we=0`.
    - At the edge: `data_q<=bus_din`, go to WRITE.
  - WRITE:
    - `bus_a=DEST_ADDR`, `bus_dout=data_q`, `bus_we=1`.
    - At the edge: `addr_lo<=addr_lo+1` (8-bit, wraps, never carries into `page`), `count<=count+1`.
    - If `count==XFER_LEN-1`, go to IDLE; else go to READ.
- Outputs outside IDLE: `cpu_rdy=0`, `dma_busy=1`. Both are combinational decodes of state.
- Latency:
  - Stall is 1 + 2*XFER_LEN cycles (513) when HALT sees `par==0`, 514 otherwise.
  - `cpu_rdy` is low from the cycle after the trigger edge.
  - `cpu_rdy` returns to 1 in the cycle after the final WRITE.
- CPU activity while not in IDLE: `cpu_a`, `cpu_dout` and `cpu_we` are ignored. A trigger-address write during a transfer does not restart it or change `page`.
- Back-to-back: a trigger write in the first IDLE cycle after completion starts a new transfer normally.
- `page == 8'hFF`: reads cover `16'hFF00` to `16'hFFFF`; the address never wraps to 0000.
- Reset mid-transfer: abort immediately to reset values. No further `bus_we`. Partial writes are not undone.
- No combinational path from `bus_din` to any output.

Test Plan:
- Idle pass-through: CPU writes 8'h5A to 16'h0300 -> `bus_a=16'h0300`, `bus_dout=8'h5A`, `bus_we=1`, `cpu_rdy=1`, `dma_busy=0`.
- Even-aligned transfer: memory[16'h0200+i]=i^8'hA5; write 8'h02 to 16'h4014 with HALT `par==0` -> exactly 256 writes to 16'h2004, data i^8'hA5 in order; `cpu_rdy` low for exactly 513 cycles.
- Odd alignment: same transfer, trigger timed so HALT sees `par==1` -> one ALIGN cycle with `bus_we=0`; `cpu_rdy` low for 514 cycles; data identical.
- Retrigger ignored: during transfer, drive `cpu_we=1`, `cpu_a=16'h4014`, `cpu_dout=8'h07` -> source stays page 02; total writes still 256.
- Page FF boundary: trigger with 8'hFF -> last read address 16'hFFFF; no read of 16'h0000; returns to IDLE.
- Reset mid-operation: assert `rst` asynchronously after 100 writes -> `cpu_rdy=1`, `dma_busy=0`, `bus_we` follows `cpu_we` immediately; a new trigger after release performs a full 256-byte transfer.
